// File: rtl/and_64_bit.sv
// 64-bit bitwise AND for the Y86 ALU logic group: combinational result plus a
// registered copy with zero/sign flags. Define AND64_GATE_LEVEL_EN for a structural datapath.
module and_64_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [64:1] a,
  input  logic [64:1] b,
  input  logic        in_valid,
  output logic [64:1] result,
  output logic [64:1] result_r,
  output logic        zf_r,
  output logic        sf_r,
  output logic        out_valid
);

  logic zf_p0;
  logic sf_p0;

`ifdef AND64_GATE_LEVEL_EN
  wire [64:1]  prod;
  wire [127:1] tree;
  wire         zf_w;

  // Heap-ordered OR tree: leaves tree[64..127], root tree[1], six levels deep.
  for (genvar i = 1; i <= 64; i++) begin : g_and
    and u_and (prod[i], a[i], b[i]);
    assign tree[63+i] = prod[i];
  end

  for (genvar n = 1; n <= 63; n++) begin : g_or
    or u_or (tree[n], tree[2*n], tree[2*n+1]);
  end

  not u_zf (zf_w, tree[1]);

  assign result = prod;
  assign zf_p0  = zf_w;
  assign sf_p0  = prod[64];
`else
  assign result = a & b;
  assign zf_p0  = ~|result;
  assign sf_p0  = result[64];
`endif

  // Stage p0 -> registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r  <= '0;
      zf_r      <= 1'b0;
      sf_r      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result_r <= result;
        zf_r     <= zf_p0;
        sf_r     <= sf_p0;
      end
    end
  end

endmodule

// File: tb/tb_and_64_bit.sv
// Self-checking bench for and_64_bit: directed vectors, reset cases and random
// traffic checked against a queue-based scoreboard.
module tb_and_64_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [64:1] a;
  logic [64:1] b;
  logic        in_valid;
  logic [64:1] result;
  logic [64:1] result_r;
  logic        zf_r;
  logic        sf_r;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [65:0] sb_q[$];   // {sf, zf, result}
  logic [63:0] mdl_res = '0;
  logic        mdl_zf  = 1'b0;
  logic        mdl_sf  = 1'b0;
  logic        mdl_ov  = 1'b0;

  and_64_bit dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .result   (result),
    .result_r (result_r),
    .zf_r     (zf_r),
    .sf_r     (sf_r),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [63:0] av, input logic [63:0] bv, input logic v, input logic r);
    logic [63:0] prod;
    logic [65:0] ent;
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = v;
    rst      = r;
    prod     = av & bv;
    #1;
    check("result", result, prod);
    if (v && !r) sb_q.push_back({prod[63], (prod == 64'h0), prod});
    @(posedge clk);
    #1;
    if (r) begin
      sb_q.delete();
      mdl_res = '0;
      mdl_zf  = 1'b0;
      mdl_sf  = 1'b0;
      mdl_ov  = 1'b0;
    end else if (v) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: empty queue on accept");
      end else begin
        ent     = sb_q.pop_front();
        mdl_res = ent[63:0];
        mdl_zf  = ent[64];
        mdl_sf  = ent[65];
      end
      mdl_ov = 1'b1;
    end else begin
      mdl_ov = 1'b0;
    end
    check("result_r",  result_r,  mdl_res);
    check("zf_r",      64'(zf_r), 64'(mdl_zf));
    check("sf_r",      64'(sf_r), 64'(mdl_sf));
    check("out_valid", 64'(out_valid), 64'(mdl_ov));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    // reset state, with a nonzero operand presented
    step(64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    step(64'h0, 64'h0, 1'b0, 1'b1);

    // directed vectors
    step(64'h9111_1111_1111_1111, 64'hEEEE_EEEE_EEEE_EEEE, 1'b1, 1'b0);
    step(64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
    step(64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
    step(64'hC4F5_4004_A1EB_66BE, 64'h0, 1'b1, 1'b0);
    // idle cycle: hold data, drop out_valid
    step(64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // reset and hold
    step(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    step(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 1'b1);
    step(64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    step(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      step({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
